// File: rtl/wire_pipe_pkg.sv
// Shared helpers for wire_pipe: occupancy counter width derived from the slot count.
package wire_pipe_pkg;

  // A zero-slot pipe still exposes a 1-bit count port so the port list never changes shape.
  function automatic int cnt_w(input int stages);
    int w;
    w = $clog2(stages + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/wire_pipe_stage.sv
// One register slot of wire_pipe: valid/data flops plus the slot's ready term.
module wire_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // An empty slot can always take a word; a full one only if it can pass its own on.
  assign ready = ~valid_q | dn_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (ready) begin
      valid_d = up_valid;
      // Bubbles leave the old payload in place so the data flops toggle less.
      if (up_valid) begin
        data_d = up_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/wire_pipe.sv
// Stallable retiming pipe: STAGES register slots with valid/ready, flush and occupancy count.
module wire_pipe
  import wire_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      out_ready,
  output logic [cnt_w(STAGES)-1:0]  count
);

  localparam int CW = cnt_w(STAGES);

  // Handshake: a word moves across a port on every rising edge where that port's
  // valid and ready are both high; valid may not wait on ready, and a producer
  // holding valid while ready is low must keep its data stable until the transfer.

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } slot_t;

  generate
    if (STAGES == 0) begin : g_wire
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst, flush};
      assign out_valid   = in_valid;
      assign out_data    = in_data;
      assign in_ready    = out_ready;
      assign count       = '0;
    end else begin : g_pipe
      slot_t         tail;
      logic          in_xfer, out_xfer;
      logic [CW-1:0] count_q, count_d;

      // Ready ripples back from the output through each slot; per-slot nets keep the chain acyclic.
      for (genvar i = 0; i < STAGES; i++) begin : g_slot
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic             dn_ready;
        logic             slot_ready;
        logic             slot_valid;
        logic [WIDTH-1:0] slot_data;

        if (i == 0) begin : g_head
          assign up_valid = in_valid;
          assign up_data  = in_data;
        end else begin : g_link
          assign up_valid = g_slot[i-1].slot_valid;
          assign up_data  = g_slot[i-1].slot_data;
        end

        if (i == STAGES - 1) begin : g_tail
          assign dn_ready = out_ready;
        end else begin : g_mid
          assign dn_ready = g_slot[i+1].slot_ready;
        end

        wire_pipe_stage #(
          .WIDTH (WIDTH)
        ) u_stage (
          .clk      (clk),
          .rst      (rst),
          .flush    (flush),
          .up_valid (up_valid),
          .up_data  (up_data),
          .dn_ready (dn_ready),
          .ready    (slot_ready),
          .valid    (slot_valid),
          .data     (slot_data)
        );
      end

      assign tail      = '{valid: g_slot[STAGES-1].slot_valid, data: g_slot[STAGES-1].slot_data};
      assign in_ready  = g_slot[0].slot_ready & ~flush;
      assign out_valid = tail.valid & ~flush;
      assign out_data  = tail.data;

      assign in_xfer  = in_valid & in_ready;
      assign out_xfer = out_valid & out_ready;

      // Both ports gated by flush, so a flush edge never counts a transfer.
      always_comb begin
        count_d = count_q;
        if (flush) begin
          count_d = '0;
        end else if (in_xfer && !out_xfer) begin
          count_d = count_q + CW'(1);
        end else if (!in_xfer && out_xfer) begin
          count_d = count_q - CW'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count_q <= '0;
        end else begin
          count_q <= count_d;
        end
      end

      assign count = count_q;
    end
  endgenerate

endmodule

// File: tb/tb_wire_pipe.sv
// Directed and randomised checks of wire_pipe across several STAGES/WIDTH settings.
module tb_wire_pipe;
  import wire_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // u_a: WIDTH=8, STAGES=2
  logic       a_flush = 0, a_in_valid = 0, a_out_ready = 0;
  logic [7:0] a_in_data = '0;
  logic       a_in_ready, a_out_valid;
  logic [7:0] a_out_data;
  logic [1:0] a_count;

  // u_b: WIDTH=8, STAGES=3
  logic       b_flush = 0, b_in_valid = 0, b_out_ready = 0;
  logic [7:0] b_in_data = '0;
  logic       b_in_ready, b_out_valid;
  logic [7:0] b_out_data;
  logic [1:0] b_count;

  // u_z: WIDTH=8, STAGES=0
  logic       z_flush = 0, z_in_valid = 0, z_out_ready = 0;
  logic [7:0] z_in_data = '0;
  logic       z_in_ready, z_out_valid;
  logic [7:0] z_out_data;
  logic [0:0] z_count;

  // Random-traffic instances: WIDTH=16, STAGES = 1, 2, 4
  logic        no_flush = 1'b0;
  logic        r_in_valid  [3] = '{0, 0, 0};
  logic        r_out_ready [3] = '{0, 0, 0};
  logic [15:0] r_in_data   [3] = '{0, 0, 0};
  logic        r_in_ready  [3];
  logic        r_out_valid [3];
  logic [15:0] r_out_data  [3];
  logic [2:0]  r_count     [3];

  logic [15:0] exp_q[$];

  wire_pipe #(.WIDTH(8), .STAGES(2)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_ready(a_out_ready), .count(a_count));

  wire_pipe #(.WIDTH(8), .STAGES(3)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_ready(b_out_ready), .count(b_count));

  wire_pipe #(.WIDTH(8), .STAGES(0)) u_z (
    .clk(clk), .rst(rst), .flush(z_flush), .in_valid(z_in_valid), .in_data(z_in_data),
    .in_ready(z_in_ready), .out_valid(z_out_valid), .out_data(z_out_data),
    .out_ready(z_out_ready), .count(z_count));

  for (genvar gk = 0; gk < 3; gk++) begin : g_rnd
    localparam int S = (gk == 0) ? 1 : (gk == 1) ? 2 : 4;
    logic [cnt_w(S)-1:0] cnt;
    wire_pipe #(.WIDTH(16), .STAGES(S)) u_dut (
      .clk(clk), .rst(rst), .flush(no_flush), .in_valid(r_in_valid[gk]),
      .in_data(r_in_data[gk]), .in_ready(r_in_ready[gk]), .out_valid(r_out_valid[gk]),
      .out_data(r_out_data[gk]), .out_ready(r_out_ready[gk]), .count(cnt));
    assign r_count[gk] = 3'(cnt);
  end

  task automatic test_reset();
    #3;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_out_valid got=%b exp=0", a_out_valid); end
    n_cmp++; if (a_out_data !== 8'h00) begin n_fail++; $display("FAIL reset_a_out_data got=%h exp=00", a_out_data); end
    n_cmp++; if (a_count !== 2'd0) begin n_fail++; $display("FAIL reset_a_count got=%0d exp=0", a_count); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_a_in_ready got=%b exp=1", a_in_ready); end
    n_cmp++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_out_valid got=%b exp=0", b_out_valid); end
    n_cmp++; if (b_count !== 2'd0) begin n_fail++; $display("FAIL reset_b_count got=%0d exp=0", b_count); end
    n_cmp++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_b_in_ready got=%b exp=1", b_in_ready); end
    n_cmp++; if (z_count !== 1'b0) begin n_fail++; $display("FAIL reset_z_count got=%0d exp=0", z_count); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // STAGES=2, out_ready high, 0x01..0x10 back to back.
  task automatic test_back_to_back();
    int acc, emit;
    logic [1:0] exp_c;
    logic exp_v;
    a_out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      a_in_valid = (n < 16);
      a_in_data  = 8'(n + 1);
      #1;
      acc   = (n < 16) ? n : 16;
      emit  = (n < 2) ? 0 : ((n - 2 < 16) ? n - 2 : 16);
      exp_c = 2'(acc - emit);
      exp_v = (n >= 2) && (n < 18);
      n_cmp++; if (a_count !== exp_c) begin n_fail++; $display("FAIL b2b_count n=%0d got=%0d exp=%0d", n, a_count, exp_c); end
      n_cmp++; if (a_out_valid !== exp_v) begin n_fail++; $display("FAIL b2b_out_valid n=%0d got=%b exp=%b", n, a_out_valid, exp_v); end
      n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready n=%0d got=%b exp=1", n, a_in_ready); end
      if (exp_v) begin
        n_cmp++; if (a_out_data !== 8'(n - 1)) begin n_fail++; $display("FAIL b2b_out_data n=%0d got=%h exp=%h", n, a_out_data, 8'(n - 1)); end
      end
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
  endtask

  // STAGES=3: fill to full with out_ready low, then drain.
  task automatic test_fill();
    logic [7:0] words [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    logic       exp_ir [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] exp_c  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic       exp_ov [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] exp_od [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h00};
    logic [1:0] exp_dc [5] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    b_out_ready = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      b_in_valid = 1'b1;
      b_in_data  = words[(n < 3) ? n : 3];
      #1;
      n_cmp++; if (b_in_ready !== exp_ir[n]) begin n_fail++; $display("FAIL fill_in_ready n=%0d got=%b exp=%b", n, b_in_ready, exp_ir[n]); end
      n_cmp++; if (b_count !== exp_c[n]) begin n_fail++; $display("FAIL fill_count n=%0d got=%0d exp=%0d", n, b_count, exp_c[n]); end
    end
    n_cmp++; if (b_out_data !== 8'hA1) begin n_fail++; $display("FAIL fill_held_head got=%h exp=a1", b_out_data); end
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      b_out_ready = 1'b1;
      b_in_valid  = (n == 0);
      #1;
      if (n == 0) begin
        n_cmp++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_full_pass in_ready got=%b exp=1", b_in_ready); end
      end
      n_cmp++; if (b_out_valid !== exp_ov[n]) begin n_fail++; $display("FAIL drain_out_valid n=%0d got=%b exp=%b", n, b_out_valid, exp_ov[n]); end
      if (exp_ov[n]) begin
        n_cmp++; if (b_out_data !== exp_od[n]) begin n_fail++; $display("FAIL drain_out_data n=%0d got=%h exp=%h", n, b_out_data, exp_od[n]); end
      end
      n_cmp++; if (b_count !== exp_dc[n]) begin n_fail++; $display("FAIL drain_count n=%0d got=%0d exp=%0d", n, b_count, exp_dc[n]); end
    end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;
  endtask

  // STAGES=3: flush with two words held and a third offered.
  task automatic test_flush();
    @(negedge clk); b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 8'h55;
    @(negedge clk); b_in_data = 8'h66;
    @(negedge clk); b_in_valid = 1'b0;
    #1;
    n_cmp++; if (b_count !== 2'd2) begin n_fail++; $display("FAIL flush_pre_count got=%0d exp=2", b_count); end
    @(negedge clk);
    #1;
    n_cmp++; if (b_out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_out_valid got=%b exp=1", b_out_valid); end
    b_flush = 1'b1; b_in_valid = 1'b1; b_in_data = 8'h77;
    #1;
    n_cmp++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=0", b_in_ready); end
    n_cmp++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%b exp=0", b_out_valid); end
    @(negedge clk);
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    #1;
    n_cmp++; if (b_count !== 2'd0) begin n_fail++; $display("FAIL flush_post_count got=%0d exp=0", b_count); end
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      #1;
      n_cmp++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak n=%0d out_valid=%b data=%h exp=0", n, b_out_valid, b_out_data); end
    end
    @(negedge clk); b_in_valid = 1'b1; b_in_data = 8'h88;
    @(negedge clk); b_in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++; if (b_out_valid !== 1'b1 || b_out_data !== 8'h88) begin n_fail++; $display("FAIL flush_recover got=%b/%h exp=1/88", b_out_valid, b_out_data); end
    @(negedge clk);
    b_out_ready = 1'b0;
  endtask

  // STAGES=2: asynchronous reset between edges with two words held.
  task automatic test_mid_reset();
    @(negedge clk); a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 8'h21;
    @(negedge clk); a_in_data = 8'h22;
    @(negedge clk); a_in_valid = 1'b0;
    #1;
    n_cmp++; if (a_count !== 2'd2 || a_out_valid !== 1'b1 || a_out_data !== 8'h21) begin
      n_fail++; $display("FAIL mrst_pre got=%0d/%b/%h exp=2/1/21", a_count, a_out_valid, a_out_data);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_out_valid got=%b exp=0", a_out_valid); end
    n_cmp++; if (a_out_data !== 8'h00) begin n_fail++; $display("FAIL mrst_out_data got=%h exp=00", a_out_data); end
    n_cmp++; if (a_count !== 2'd0) begin n_fail++; $display("FAIL mrst_count got=%0d exp=0", a_count); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_in_ready got=%b exp=1", a_in_ready); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); a_in_valid = 1'b1; a_in_data = 8'h9A; a_out_ready = 1'b1;
    @(negedge clk); a_in_valid = 1'b0;
    #1;
    n_cmp++; if (a_out_valid !== 1'b0 || a_count !== 2'd1) begin n_fail++; $display("FAIL mrst_lat1 got=%b/%0d exp=0/1", a_out_valid, a_count); end
    @(negedge clk);
    #1;
    n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h9A) begin n_fail++; $display("FAIL mrst_lat2 got=%b/%h exp=1/9a", a_out_valid, a_out_data); end
    @(negedge clk);
    #1;
    n_cmp++; if (a_out_valid !== 1'b0 || a_count !== 2'd0) begin n_fail++; $display("FAIL mrst_drained got=%b/%0d exp=0/0", a_out_valid, a_count); end
    a_out_ready = 1'b0;
  endtask

  // STAGES=0: pure combinational wire, flush ignored.
  task automatic test_stages0();
    @(negedge clk);
    z_in_valid = 1'b1; z_in_data = 8'h3C; z_out_ready = 1'b1;
    #1;
    n_cmp++; if (z_out_valid !== 1'b1 || z_out_data !== 8'h3C) begin n_fail++; $display("FAIL s0_pass1 got=%b/%h exp=1/3c", z_out_valid, z_out_data); end
    n_cmp++; if (z_in_ready !== 1'b1) begin n_fail++; $display("FAIL s0_ready1 got=%b exp=1", z_in_ready); end
    z_in_valid = 1'b0; z_in_data = 8'hC3; z_out_ready = 1'b0;
    #1;
    n_cmp++; if (z_out_valid !== 1'b0 || z_out_data !== 8'hC3) begin n_fail++; $display("FAIL s0_pass2 got=%b/%h exp=0/c3", z_out_valid, z_out_data); end
    n_cmp++; if (z_in_ready !== 1'b0) begin n_fail++; $display("FAIL s0_ready2 got=%b exp=0", z_in_ready); end
    z_flush = 1'b1; z_in_valid = 1'b1; z_out_ready = 1'b1;
    #1;
    n_cmp++; if (z_out_valid !== 1'b1 || z_in_ready !== 1'b1) begin n_fail++; $display("FAIL s0_flush got=%b/%b exp=1/1", z_out_valid, z_in_ready); end
    @(negedge clk);
    #1;
    n_cmp++; if (z_count !== 1'b0) begin n_fail++; $display("FAIL s0_count got=%0d exp=0", z_count); end
    z_flush = 1'b0; z_in_valid = 1'b0; z_out_ready = 1'b0;
  endtask

  // Random valid/ready traffic against a queue model of the held words.
  task automatic test_random(input int k, input int s, input int nwords);
    int   sent, got, cycles;
    logic hold, in_x, out_x;
    exp_q.delete();
    sent = 0; got = 0; cycles = 0; hold = 1'b0;
    while (got < nwords && cycles < 20 * nwords) begin
      @(negedge clk);
      cycles++;
      r_out_ready[k] = 1'($urandom_range(0, 1));
      if (!hold) begin
        if (sent < nwords && $urandom_range(0, 1) == 1) begin
          r_in_valid[k] = 1'b1;
          r_in_data[k]  = 16'($urandom_range(0, 65535));
        end else begin
          r_in_valid[k] = 1'b0;
        end
      end
      #1;
      n_cmp++; if (r_count[k] !== 3'(exp_q.size())) begin n_fail++; $display("FAIL rnd_count s=%0d cyc=%0d got=%0d exp=%0d", s, cycles, r_count[k], exp_q.size()); end
      n_cmp++; if (r_in_ready[k] !== ((exp_q.size() < s) || r_out_ready[k])) begin
        n_fail++; $display("FAIL rnd_in_ready s=%0d cyc=%0d got=%b depth=%0d out_ready=%b", s, cycles, r_in_ready[k], exp_q.size(), r_out_ready[k]);
      end
      if (r_out_valid[k]) begin
        n_cmp++; if (exp_q.size() == 0 || r_out_data[k] !== exp_q[0]) begin
          n_fail++; $display("FAIL rnd_out_data s=%0d cyc=%0d got=%h exp=%h depth=%0d", s, cycles, r_out_data[k], (exp_q.size() > 0) ? exp_q[0] : 16'h0, exp_q.size());
        end
      end
      in_x  = r_in_valid[k] & r_in_ready[k];
      out_x = r_out_valid[k] & r_out_ready[k];
      @(posedge clk);
      if (out_x && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        got++;
      end
      if (in_x) begin
        exp_q.push_back(r_in_data[k]);
        sent++;
      end
      hold = r_in_valid[k] & ~in_x;
    end
    r_in_valid[k]  = 1'b0;
    r_out_ready[k] = 1'b0;
    n_cmp++; if (got != nwords) begin n_fail++; $display("FAIL rnd_timeout s=%0d got=%0d exp=%0d words", s, got, nwords); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_fill();
    test_flush();
    test_mid_reset();
    test_stages0();
    test_random(0, 1, 1000);
    test_random(1, 2, 1000);
    test_random(2, 4, 1000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
